// File: rtl/program_loader.sv
// Byte-stream program loader: LE length, LE halfwords to instr memory, CPU held in reset until done.
// Latency: write strobe the cycle after each halfword's 2nd byte; byte_ready_o low outside byte-taking states.
// Backpressure: stalled byte_valid_i freezes everything. LOADER_CHECKSUM_EN adds a trailing XOR checksum.
module program_loader #(
  parameter int ADDR_STEP = 1,
  parameter int MAX_INSTR = 256,
  parameter int WORD = 32,
  localparam int HALF_WORD = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [15:0]          instr_count_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, DONE, ERROR, CHK_LO, CHK_HI
  } state_e;
`else
  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, DONE, ERROR
  } state_e;
`endif

  localparam logic [15:0]     MAX_LEN  = 16'(MAX_INSTR);
  localparam logic [WORD-1:0] ADDR_INC = WORD'(ADDR_STEP);

  state_e                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [HALF_WORD-1:0]   instr_q, instr_d;
  logic [WORD-1:0]        addr_q, addr_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            len_full;
  logic                   xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [HALF_WORD-1:0]   csum_q, csum_d;
  logic [7:0]             chk_lo_q, chk_lo_d;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      instr_q  <= '0;
      addr_q   <= '0;
      count_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
      chk_lo_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
      chk_lo_q <= chk_lo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    count_d  = count_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    chk_lo_d = chk_lo_q;
`endif
    byte_ready_o           = 1'b0;
    program_mem_write_en_o = 1'b0;
    cpu_reset_o            = 1'b1;
    busy_o                 = 1'b0;
    done_o                 = 1'b0;
    error_o                = 1'b0;
    len_full               = {byte_i, len_q[7:0]};

    case (state_q)
      LEN_LO, LEN_HI, DATA_LO, DATA_HI: byte_ready_o = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK_LO, CHK_HI: byte_ready_o = 1'b1;
`endif
      default: byte_ready_o = 1'b0;
    endcase
    xfer = byte_valid_i && byte_ready_o;

    case (state_q)
      IDLE, DONE, ERROR: begin
        done_o      = (state_q == DONE);
        error_o     = (state_q == ERROR);
        cpu_reset_o = (state_q != DONE);
        // A new load clears the previous result and restarts addressing at zero.
        if (start_i) begin
          state_d = LEN_LO;
          count_d = '0;
          addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN_LO: begin
        busy_o = 1'b1;
        if (xfer) begin
          len_d[7:0] = byte_i;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        busy_o = 1'b1;
        if (xfer) begin
          len_d = len_full;
          if (len_full == 16'd0 || len_full > MAX_LEN) state_d = ERROR;
          else                                          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        busy_o = 1'b1;
        if (xfer) begin
          instr_d[7:0] = byte_i;
          state_d      = DATA_HI;
        end
      end
      DATA_HI: begin
        busy_o = 1'b1;
        if (xfer) begin
          instr_d[15:8] = byte_i;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        busy_o                 = 1'b1;
        program_mem_write_en_o = 1'b1;
        count_d                = count_q + 16'd1;
        addr_d                 = addr_q + ADDR_INC;
`ifdef LOADER_CHECKSUM_EN
        csum_d                 = csum_q ^ instr_q;
        state_d                = (count_q + 16'd1 == len_q) ? CHK_LO : DATA_LO;
`else
        state_d                = (count_q + 16'd1 == len_q) ? DONE : DATA_LO;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK_LO: begin
        busy_o = 1'b1;
        if (xfer) begin
          chk_lo_d = byte_i;
          state_d  = CHK_HI;
        end
      end
      CHK_HI: begin
        busy_o = 1'b1;
        if (xfer) state_d = ({byte_i, chk_lo_q} == csum_q) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign instruction_o      = instr_q;
  assign instruction_addr_o = addr_q;
  assign instr_count_o      = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized directed bench for program_loader, scored against a stream-parsing reference model.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_checks++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_program_loader;
  localparam int MAXI = 256;
  localparam int STEP = 1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_i, start_i, byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, program_mem_write_en_o, cpu_reset_o, busy_o, done_o, error_o;
  logic [15:0] instruction_o, instr_count_o;
  logic [31:0] instruction_addr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bad_rdy  = 0;
  wr_t wq[$];

  program_loader #(.ADDR_STEP(STEP), .MAX_INSTR(MAXI)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .program_mem_write_en_o(program_mem_write_en_o), .instruction_o(instruction_o),
    .instruction_addr_o(instruction_addr_o), .cpu_reset_o(cpu_reset_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .instr_count_o(instr_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (program_mem_write_en_o) begin
      wr_t w;
      w.addr = instruction_addr_o;
      w.data = instruction_o;
      w.cyc  = cyc;
      wq.push_back(w);
      if (byte_ready_o) bad_rdy++;
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic check_reset_outputs(input string tag);
    `CHK({tag, ".byte_ready"}, byte_ready_o, 1'b0)
    `CHK({tag, ".wr_en"}, program_mem_write_en_o, 1'b0)
    `CHK({tag, ".instr"}, instruction_o, 16'h0)
    `CHK({tag, ".addr"}, instruction_addr_o, 32'h0)
    `CHK({tag, ".cpu_reset"}, cpu_reset_o, 1'b1)
    `CHK({tag, ".busy"}, busy_o, 1'b0)
    `CHK({tag, ".done"}, done_o, 1'b0)
    `CHK({tag, ".error"}, error_o, 1'b0)
    `CHK({tag, ".count"}, instr_count_o, 16'h0)
  endtask

  // Called at posedge+1; returns at posedge+1 after the start pulse was sampled.
  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start, output int acc);
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid_i = 1'b1;
    byte_i       = b;
    start_i      = with_start;
    acc          = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (byte_ready_o) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    byte_valid_i = 1'b0;
    start_i      = 1'b0;
    byte_i       = 8'($urandom);
    `CHK("byte_accept_timeout", (acc >= 0), 1'b1)
  endtask

  function automatic bq_t with_chk(bq_t q);
    bq_t r = q;
`ifdef LOADER_CHECKSUM_EN
    int          n = {q[1], q[0]};
    logic [15:0] x = 16'h0;
    for (int i = 0; i < n; i++) x ^= {q[3+2*i], q[2+2*i]};
    r.push_back(x[7:0]);
    r.push_back(x[15:8]);
`endif
    return r;
  endfunction

  function automatic bq_t rand_stream(int n);
    bq_t         q;
    logic [15:0] l = 16'(n);
    q.push_back(l[7:0]);
    q.push_back(l[15:8]);
    for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
    return with_chk(q);
  endfunction

  task automatic run_load(input string tag, input bq_t s, input int maxgap, input int start_at);
    int          n_len = {s[1], s[0]};
    bit          len_err = (n_len == 0) || (n_len > MAXI);
    bit          exp_err = len_err;
    int          exp_n = len_err ? 0 : n_len;
    logic [15:0] ed[$];
    logic [15:0] x = 16'h0;
    int          acc[$];
    int          base = wq.size();
    int          a;

    for (int i = 0; i < exp_n; i++) begin
      ed.push_back({s[3+2*i], s[2+2*i]});
      x ^= ed[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (!len_err) exp_err = ({s[3+2*n_len], s[2+2*n_len]} != x);
`endif

    pulse_start();
    @(negedge clk);
    `CHK({tag, ".start_busy"}, busy_o, 1'b1)
    `CHK({tag, ".start_done_clr"}, done_o, 1'b0)
    `CHK({tag, ".start_err_clr"}, error_o, 1'b0)
    `CHK({tag, ".start_cnt_clr"}, instr_count_o, 16'h0)
    `CHK({tag, ".start_ready"}, byte_ready_o, 1'b1)
    @(posedge clk); #1;

    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], $urandom_range(0, maxgap), (i == start_at), a);
      acc.push_back(a);
    end

`ifndef LOADER_CHECKSUM_EN
    if (!len_err) begin
      @(negedge clk);
      `CHK({tag, ".last_strobe"}, program_mem_write_en_o, 1'b1)
      `CHK({tag, ".cpu_rst_at_strobe"}, cpu_reset_o, 1'b1)
      @(negedge clk);
      `CHK({tag, ".cpu_rst_fall"}, cpu_reset_o, 1'b0)
      `CHK({tag, ".done_after_strobe"}, done_o, 1'b1)
    end
`endif
    repeat (2) @(negedge clk);

    `CHK({tag, ".done"}, done_o, !exp_err)
    `CHK({tag, ".error"}, error_o, exp_err)
    `CHK({tag, ".cpu_reset"}, cpu_reset_o, exp_err)
    `CHK({tag, ".busy"}, busy_o, 1'b0)
    `CHK({tag, ".ready"}, byte_ready_o, 1'b0)
    `CHK({tag, ".count"}, instr_count_o, 16'(exp_n))
    `CHK({tag, ".n_writes"}, wq.size() - base, exp_n)
    `CHK({tag, ".ready_in_write"}, bad_rdy, 0)
    for (int i = 0; i < exp_n && base + i < wq.size(); i++) begin
      `CHK({tag, ".wr_addr"}, wq[base+i].addr, 32'(i * STEP))
      `CHK({tag, ".wr_data"}, wq[base+i].data, ed[i])
      `CHK({tag, ".wr_latency"}, wq[base+i].cyc, acc[3+2*i])
    end
    if (exp_n > 0) begin
      `CHK({tag, ".final_addr"}, instruction_addr_o, 32'(exp_n * STEP))
      `CHK({tag, ".final_instr"}, instruction_o, ed[exp_n-1])
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bq_t base_s;
    int  a;
    int  nw;

    reset_i      = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
    @(posedge clk); #1;

    base_s = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    run_load("basic", with_chk(base_s), 0, -1);
    run_load("gaps_start_ignored", with_chk(base_s), 5, 2);

    run_load("len_zero", bq_t'{8'h00, 8'h00}, 2, -1);
    run_load("len_257", bq_t'{8'h01, 8'h01}, 0, -1);
    run_load("len_256", rand_stream(256), 0, -1);

    for (int t = 0; t < 6; t++)
      run_load("random", rand_stream($urandom_range(1, 8)), 3, -1);

    // Reset asserted while waiting for the upper data byte.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(base_s[i], 0, 1'b0, a);
    nw = wq.size();
    #2 reset_i = 1'b0;
    #1;
    check_reset_outputs("mid_load_reset");
    repeat (3) @(negedge clk);
    `CHK("mid_load_no_strobe", wq.size() - nw, 0)
    @(posedge clk); #1 reset_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_load_release");
    @(posedge clk); #1;
    run_load("after_reset", with_chk(base_s), 1, -1);

`ifdef LOADER_CHECKSUM_EN
    run_load("chk_good", bq_t'{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h4C, 8'h44}, 0, -1);
    run_load("chk_bad", bq_t'{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00}, 2, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_STEP, default 1: instruction address increment per written halfword.
REQ-002 Parameter MAX_INSTR, default 256: largest accepted instruction count (1..65535).
REQ-003 clk_i  in  1  sole clock; all state rising-edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle load request.
REQ-006 byte_valid_i  in  1  byte_i holds a valid byte.
REQ-007 byte_i  in  8  loader stream byte.
REQ-008 byte_ready_o  out  1  loader accepts byte_i this cycle.
REQ-009 program_mem_write_en_o  out  1  instruction-memory write strobe.
REQ-010 instruction_o  out  HALF_WORD  halfword to write.
REQ-011 instruction_addr_o  out  WORD  write address.
REQ-012 cpu_reset_o  out  1  active-high hold-in-reset for the CPU.
REQ-013 busy_o  out  1  load in progress.
REQ-014 done_o  out  1  last load completed successfully.
REQ-015 error_o  out  1  last load aborted.
REQ-016 instr_count_o  out  16  halfwords written in current/last load.

Function
REQ-017 States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, DONE, ERROR (plus CHK_LO, CHK_HI when configured).
REQ-018 Byte transfer occurs only on a cycle with byte_valid_i=1 and byte_ready_o=1.
REQ-019 byte_ready_o=1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK_LO, CHK_HI; 0 in all other states.
REQ-020 start_i in IDLE, DONE or ERROR -> LEN_LO next cycle; clears done_o, error_o, instr_count_o, address counter to 0; ignored in all other states.
REQ-021 LEN_LO/LEN_HI capture 16-bit little-endian length L; after LEN_HI, L=0 or L>MAX_INSTR -> ERROR, else DATA_LO.
REQ-022 DATA_LO captures instruction_o[7:0], DATA_HI captures instruction_o[15:0] upper byte, then WRITE.
REQ-023 WRITE lasts exactly one cycle: program_mem_write_en_o=1 with stable instruction_o and instruction_addr_o; program_mem_write_en_o=0 in every other state.
REQ-024 After WRITE: instr_count_o +1, address +ADDR_STEP (modulo 2^WORD); count==L -> DONE (or CHK_LO when configured), else DATA_LO.
REQ-025 Latency: first write strobe occurs the cycle after the 4th accepted byte; each subsequent strobe the cycle after every 2nd accepted byte.
REQ-026 cpu_reset_o=1 in every state except DONE; in DONE cpu_reset_o=0, done_o=1, busy_o=0.
REQ-027 busy_o=1 in LEN_LO through WRITE/CHK_HI; 0 in IDLE, DONE, ERROR.
REQ-028 ERROR: error_o=1, cpu_reset_o=1, write strobe 0; exits only on start_i.
REQ-029 Stalled byte_valid_i (any length) holds state and all outputs unchanged.
REQ-030 start_i coincident with a byte transfer in a busy state: start ignored, byte consumed normally.

Reset
REQ-031 reset_i low asynchronously forces IDLE; byte_ready_o=0, program_mem_write_en_o=0, instruction_o=0, instruction_addr_o=0, cpu_reset_o=1, busy_o=0, done_o=0, error_o=0, instr_count_o=0.
REQ-032 Reset mid-load abandons the load; no partial write strobe is produced; release of reset_i returns to IDLE behaviour on the next rising edge.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN: defined -> after last WRITE, CHK_LO/CHK_HI receive 16-bit little-endian value; equal to XOR of all written halfwords -> DONE, else ERROR.
REQ-034 LOADER_CHECKSUM_EN undefined -> no CHK states, no checksum logic; last WRITE goes directly to DONE.

Verification
REQ-035 Reset, start_i, bytes 02 00 34 12 78 56 -> writes 0x1234@0, 0x5678@1, instr_count_o=2, done_o=1, cpu_reset_o falls to 0 next cycle after second strobe.
REQ-036 Length bytes 00 00 -> ERROR, error_o=1, no write strobe, cpu_reset_o stays 1; new start_i clears error_o.
REQ-037 MAX_INSTR=256, length 01 01 (257) -> ERROR; length 00 01 (256) accepted, last address 255.
REQ-038 Random byte_valid_i gaps of 0-5 cycles -> identical writes/addresses to REQ-035; byte_ready_o low during WRITE.
REQ-039 reset_i low between DATA_LO and DATA_HI -> immediate IDLE outputs per REQ-031, no strobe; restarted load completes correctly.
REQ-040 LOADER_CHECKSUM_EN defined: stream of REQ-035 plus 4C 44 -> DONE; plus 00 00 -> ERROR.
